// File: rtl/wb_bram_pkg.sv
// Shared definitions for the Wishbone block-RAM slave.
//   - FSM state encodings (plain constants so older tools accept them)
//   - access counter and read wait counter widths
//   - helper for the byte-offset bit count of a data bus
//   - saturating increment used by the access counter
package wb_bram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RWAIT = 2'd1;
  localparam state_t ST_RESP  = 2'd2;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 4;

  // Number of address bits that select a byte within one data word.
  function automatic int adr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction

  // Saturating increment.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wb_bram_slave_if.sv
// Wishbone classic slave-side bus bundle.
//   wbs_cyc_i / wbs_stb_i : cycle and strobe from master
//   wbs_adr_i             : byte address (AW bits)
//   wbs_we_i              : 1 = write
//   wbs_sel_i             : byte lane enables (DW/8 bits)
//   wbs_dat_i             : write data
//   wbs_dat_o             : read data, valid only with wbs_ack_o
//   wbs_ack_o / wbs_err_o : one-cycle acknowledge / error
interface wb_bram_slave_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic            wbs_cyc_i;
  logic            wbs_stb_i;
  logic [AW-1:0]   wbs_adr_i;
  logic            wbs_we_i;
  logic [DW/8-1:0] wbs_sel_i;
  logic [DW-1:0]   wbs_dat_i;
  logic [DW-1:0]   wbs_dat_o;
  logic            wbs_ack_o;
  logic            wbs_err_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o, wbs_err_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_adr_i, wbs_we_i, wbs_sel_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o, wbs_err_o
  );

endinterface

// File: rtl/wb_bram_core.sv
// Single-port RAM with synchronous read and per-byte write enables.
// Written so FPGA tools infer a block RAM: no reset on the array, registered
// read output that only updates on a read strobe.
//   clk_i   : clock
//   rdEn_i  : read strobe; rdata_o updates on the next edge and then holds
//   wrEn_i  : write strobe
//   be_i    : byte lane enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module wb_bram_core #(
  parameter int DW         = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rdEn_i,
  input  logic                  wrEn_i,
  input  logic [DW/8-1:0]       be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DW-1:0]         wdata_i,
  output logic [DW-1:0]         rdata_o
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [DW-1:0] mem [DEPTH];

  // Byte-lane writes and registered read. rdata_o holds between reads so the
  // slave can present it after any number of wait states.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) begin
          mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
    if (rdEn_i) begin
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/wb_bram_slave.sv
// Wishbone classic slave in front of an inferred block RAM.
// Adds byte-lane writes, programmable read wait states, address window decode
// with error response, write protect, a debug trigger and an access counter.
//   sys_clk  : single clock
//   reset    : synchronous, active-high
//   wbs      : Wishbone slave bundle (cyc/stb/adr/we/sel/dat in, dat/ack/err out)
//   wp       : write protect; protected writes are answered with err
//   dbg_trig : one-cycle pulse with ack when the accessed word is TRIG_ADDR's word
//   acc_cnt  : number of acked accesses, saturating
module wb_bram_slave
  import wb_bram_pkg::*;
#(
  parameter int            DW         = 32,
  parameter int            AW         = 32,
  parameter int            DEPTH_LOG2 = 9,
  parameter logic [AW-1:0] BASE_ADDR  = '0,
  parameter int            RD_WAIT    = 0,
  parameter logic [AW-1:0] TRIG_ADDR  = '0,
  parameter                INIT_FILE  = ""
) (
  input  logic             sys_clk,
  input  logic             reset,
  wb_bram_slave_if.slave   wbs,
  input  logic             wp,
  output logic             dbg_trig,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int                ADR_LSB   = adr_lsb(DW);
  localparam logic [AW:0]       WIN_BYTES = (AW+1)'((2 ** DEPTH_LOG2) * (DW / 8));
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(RD_WAIT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              trigHit_q, trigHit_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              trig_q, trig_d;
  logic [CNT_W-1:0]  accCnt_q, accCnt_d;

  logic [AW:0]       adrOffset;
  logic              inRange;
  logic              reqTrig;
  logic              reqErr;
  logic              accept;
  logic [DW-1:0]     ramRdata;

  // Window decode on an extended offset: an address below BASE_ADDR borrows
  // into the top bit and therefore compares as out of range, and nothing wraps.
  assign adrOffset = {1'b0, wbs.wbs_adr_i} - {1'b0, BASE_ADDR};
  assign inRange   = adrOffset < WIN_BYTES;
  assign reqTrig   = wbs.wbs_adr_i[AW-1:ADR_LSB] == TRIG_ADDR[AW-1:ADR_LSB];
  assign reqErr    = !inRange || (wbs.wbs_we_i && wp);
  // Gated by reset so the RAM is never touched on a reset edge.
  assign accept    = (state_q == ST_IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i && !reset;

  wb_bram_core #(
    .DW         (DW),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) uCore (
    .clk_i   (sys_clk),
    .rdEn_i  (accept && inRange && !wbs.wbs_we_i),
    .wrEn_i  (accept && !reqErr && wbs.wbs_we_i),
    .be_i    (wbs.wbs_sel_i),
    .addr_i  (wbs.wbs_adr_i[ADR_LSB+DEPTH_LOG2-1:ADR_LSB]),
    .wdata_i (wbs.wbs_dat_i),
    .rdata_o (ramRdata)
  );

  // Next-state logic. ack/err/trig are only ever raised on the transition into
  // RESP, so each is a single-cycle pulse and ack and err can never coincide.
  // Only the trigger match is kept from the request; everything else about it
  // is already committed to the RAM at acceptance.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    trigHit_d = trigHit_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    trig_d    = 1'b0;
    accCnt_d  = accCnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          trigHit_d = reqTrig;
          if (reqErr) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (wbs.wbs_we_i || (RD_WAIT == 0)) begin
            ack_d    = 1'b1;
            trig_d   = reqTrig;
            accCnt_d = sat_inc(accCnt_q);
            state_d  = ST_RESP;
          end else begin
            waitCnt_d = WAIT_INIT;
            state_d   = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (!wbs.wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else begin
          // Respond on the edge where the counter reaches zero.
          waitCnt_d = waitCnt_q - 1'b1;
          if (waitCnt_d == '0) begin
            ack_d    = 1'b1;
            trig_d   = trigHit_q;
            accCnt_d = sat_inc(accCnt_q);
            state_d  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and response registers; RAM contents survive reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      trigHit_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      trig_q    <= 1'b0;
      accCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      trigHit_q <= trigHit_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      trig_q    <= trig_d;
      accCnt_q  <= accCnt_d;
    end
  end

  // Read data is only driven alongside ack; it is zero on err and when idle.
  assign wbs.wbs_dat_o = ack_q ? ramRdata : '0;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
  assign dbg_trig      = trig_q;
  assign acc_cnt       = accCnt_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Directed testbench for wb_bram_slave. Three instances share one set of bus
// inputs and differ only in read wait states (0, 2, 3); instance 0 also has
// its trigger at byte address 0x10. Each transaction is followed by an
// 8-cycle observation window on the selected instance.
module tb_wb_bram_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we, wp;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;

  always #5 clk = ~clk;

  wb_bram_slave_if #(.AW(32), .DW(32)) busA ();
  wb_bram_slave_if #(.AW(32), .DW(32)) busB ();
  wb_bram_slave_if #(.AW(32), .DW(32)) busC ();

  assign busA.wbs_cyc_i = cyc;
  assign busA.wbs_stb_i = stb;
  assign busA.wbs_adr_i = adr;
  assign busA.wbs_we_i  = we;
  assign busA.wbs_sel_i = sel;
  assign busA.wbs_dat_i = wdat;
  assign busB.wbs_cyc_i = cyc;
  assign busB.wbs_stb_i = stb;
  assign busB.wbs_adr_i = adr;
  assign busB.wbs_we_i  = we;
  assign busB.wbs_sel_i = sel;
  assign busB.wbs_dat_i = wdat;
  assign busC.wbs_cyc_i = cyc;
  assign busC.wbs_stb_i = stb;
  assign busC.wbs_adr_i = adr;
  assign busC.wbs_we_i  = we;
  assign busC.wbs_sel_i = sel;
  assign busC.wbs_dat_i = wdat;

  logic [2:0]  ackV, errV, trigV;
  logic [31:0] datV [3];
  logic [15:0] accV [3];

  assign ackV[0] = busA.wbs_ack_o;
  assign ackV[1] = busB.wbs_ack_o;
  assign ackV[2] = busC.wbs_ack_o;
  assign errV[0] = busA.wbs_err_o;
  assign errV[1] = busB.wbs_err_o;
  assign errV[2] = busC.wbs_err_o;
  assign datV[0] = busA.wbs_dat_o;
  assign datV[1] = busB.wbs_dat_o;
  assign datV[2] = busC.wbs_dat_o;

  wb_bram_slave #(.RD_WAIT(0), .TRIG_ADDR(32'h0000_0010)) dutA (
    .sys_clk(clk), .reset(reset), .wbs(busA), .wp(wp), .dbg_trig(trigV[0]), .acc_cnt(accV[0])
  );
  wb_bram_slave #(.RD_WAIT(2)) dutB (
    .sys_clk(clk), .reset(reset), .wbs(busB), .wp(wp), .dbg_trig(trigV[1]), .acc_cnt(accV[1])
  );
  wb_bram_slave #(.RD_WAIT(3)) dutC (
    .sys_clk(clk), .reset(reset), .wbs(busC), .wp(wp), .dbg_trig(trigV[2]), .acc_cnt(accV[2])
  );

  localparam int RDW [3] = '{0, 2, 3};

  int checks   = 0;
  int failures = 0;
  int expAcc [3];

  // Observations from the most recent transaction on the selected instance.
  int          obsAckAt, obsErrAt, obsNAck, obsNErr, obsNTrig;
  logic [31:0] obsDat, obsErrDat;
  logic        obsTrig;

  function automatic logic inWin(input logic [31:0] a);
    return a < 32'h0000_0800;
  endfunction

  // One bus transaction; stb is held for exactly one accepted edge, then all
  // request fields are scrambled to show they were latched. dropAt>0 drops cyc
  // after observing cycle k+dropAt. Also advances the expected access counts.
  task automatic tx(input int d, input logic w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] wd, input int dropAt);
    obsAckAt = 0; obsErrAt = 0; obsNAck = 0; obsNErr = 0; obsNTrig = 0;
    obsDat = 32'hxxxx_xxxx; obsErrDat = 32'hxxxx_xxxx; obsTrig = 1'bx;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = wd;
    @(posedge clk);
    #1;
    stb = 1'b0; we = ~w; adr = 32'hFFFF_FFFF; sel = ~s; wdat = ~wd;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ackV[d]) begin
        obsNAck++; obsAckAt = c; obsDat = datV[d]; obsTrig = trigV[d];
      end
      if (errV[d]) begin
        obsNErr++; obsErrAt = c; obsErrDat = datV[d];
      end
      if (trigV[d]) obsNTrig++;
      if (c == dropAt) cyc = 1'b0;
    end
    cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (inWin(a) && !(w && wp) && !(!w && dropAt > 0 && dropAt <= RDW[i])) expAcc[i]++;
    end
  endtask

  task automatic applyStimulusReset();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wp = 1'b0; adr = '0; sel = '0; wdat = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) expAcc[i] = 0;
  endtask

  task automatic test_reset();
    applyStimulusReset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ackV[d] !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack[%0d] got=%b exp=0", d, ackV[d]); end
      checks++;
      if (errV[d] !== 1'b0) begin failures++; $display("[TB] FAIL reset_err[%0d] got=%b exp=0", d, errV[d]); end
      checks++;
      if (trigV[d] !== 1'b0) begin failures++; $display("[TB] FAIL reset_trig[%0d] got=%b exp=0", d, trigV[d]); end
      checks++;
      if (datV[d] !== 32'h0) begin failures++; $display("[TB] FAIL reset_dat[%0d] got=%h exp=0", d, datV[d]); end
      checks++;
      if (accV[d] !== 16'h0) begin failures++; $display("[TB] FAIL reset_acc[%0d] got=%0d exp=0", d, accV[d]); end
    end
  endtask

  task automatic test_byte_lanes();
    tx(0, 1'b1, 32'h14, 4'hF, 32'h0000_0000, 0);
    tx(0, 1'b1, 32'h14, 4'b0011, 32'h1234_5678, 0);
    checks++;
    if (obsNAck !== 1 || obsAckAt !== 1) begin failures++; $display("[TB] FAIL write_ack n=%0d at=%0d exp n=1 at=1", obsNAck, obsAckAt); end
    tx(0, 1'b1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 0);
    tx(0, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsDat !== 32'h0000_5678) begin failures++; $display("[TB] FAIL lane_read got=%h exp=00005678", obsDat); end
    checks++;
    if (obsAckAt !== 1 || obsNErr !== 0) begin failures++; $display("[TB] FAIL read0_timing at=%0d errs=%0d exp at=1 errs=0", obsAckAt, obsNErr); end
    checks++;
    if (accV[0] !== 16'(expAcc[0])) begin failures++; $display("[TB] FAIL lanes_acc got=%0d exp=%0d", accV[0], expAcc[0]); end
  endtask

  task automatic test_read_wait();
    tx(1, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsAckAt !== 3 || obsNAck !== 1) begin failures++; $display("[TB] FAIL wait2_ack at=%0d n=%0d exp at=3 n=1", obsAckAt, obsNAck); end
    checks++;
    if (obsNErr !== 0) begin failures++; $display("[TB] FAIL wait2_err n=%0d exp=0", obsNErr); end
    checks++;
    if (obsDat !== 32'h0000_5678) begin failures++; $display("[TB] FAIL wait2_dat got=%h exp=00005678", obsDat); end
    checks++;
    if (accV[1] !== 16'(expAcc[1])) begin failures++; $display("[TB] FAIL wait2_acc got=%0d exp=%0d", accV[1], expAcc[1]); end
    tx(2, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsAckAt !== 4 || obsNAck !== 1) begin failures++; $display("[TB] FAIL wait3_ack at=%0d n=%0d exp at=4 n=1", obsAckAt, obsNAck); end
  endtask

  task automatic test_out_of_range();
    tx(0, 1'b0, 32'h800, 4'hF, 32'h0, 0);
    checks++;
    if (obsNErr !== 1 || obsErrAt !== 1) begin failures++; $display("[TB] FAIL oor_err n=%0d at=%0d exp n=1 at=1", obsNErr, obsErrAt); end
    checks++;
    if (obsNAck !== 0) begin failures++; $display("[TB] FAIL oor_ack n=%0d exp=0", obsNAck); end
    checks++;
    if (obsErrDat !== 32'h0) begin failures++; $display("[TB] FAIL oor_dat got=%h exp=0", obsErrDat); end
    checks++;
    if (accV[0] !== 16'(expAcc[0])) begin failures++; $display("[TB] FAIL oor_acc got=%0d exp=%0d", accV[0], expAcc[0]); end
    tx(0, 1'b0, 32'h7FC, 4'hF, 32'h0, 0);
    checks++;
    if (obsNAck !== 1 || obsNErr !== 0) begin failures++; $display("[TB] FAIL top_word ack=%0d err=%0d exp ack=1 err=0", obsNAck, obsNErr); end
    tx(2, 1'b1, 32'hFFFF_FFF0, 4'hF, 32'h1, 0);
    checks++;
    if (obsNErr !== 1 || obsNAck !== 0) begin failures++; $display("[TB] FAIL high_adr err=%0d ack=%0d exp err=1 ack=0", obsNErr, obsNAck); end
    checks++;
    if (accV[2] !== 16'(expAcc[2])) begin failures++; $display("[TB] FAIL high_adr_acc got=%0d exp=%0d", accV[2], expAcc[2]); end
  endtask

  task automatic test_write_protect();
    wp = 1'b0;
    tx(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 0);
    wp = 1'b1;
    tx(0, 1'b1, 32'h0, 4'hF, 32'hDEAD_BEEF, 0);
    checks++;
    if (obsNErr !== 1 || obsErrAt !== 1 || obsNAck !== 0) begin failures++; $display("[TB] FAIL wp_err err=%0d at=%0d ack=%0d exp 1/1/0", obsNErr, obsErrAt, obsNAck); end
    tx(0, 1'b0, 32'h0, 4'hF, 32'h0, 0);
    checks++;
    if (obsNAck !== 1 || obsDat !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL wp_read_ok ack=%0d got=%h exp 1/cafef00d", obsNAck, obsDat); end
    wp = 1'b0;
    tx(0, 1'b0, 32'h0, 4'hF, 32'h0, 0);
    checks++;
    if (obsDat !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL wp_kept got=%h exp=cafef00d", obsDat); end
    checks++;
    if (accV[0] !== 16'(expAcc[0])) begin failures++; $display("[TB] FAIL wp_acc got=%0d exp=%0d", accV[0], expAcc[0]); end
  endtask

  task automatic test_abort();
    tx(2, 1'b0, 32'h14, 4'hF, 32'h0, 1);
    checks++;
    if (obsNAck !== 0 || obsNErr !== 0) begin failures++; $display("[TB] FAIL abort_resp ack=%0d err=%0d exp 0/0", obsNAck, obsNErr); end
    checks++;
    if (accV[2] !== 16'(expAcc[2])) begin failures++; $display("[TB] FAIL abort_acc got=%0d exp=%0d", accV[2], expAcc[2]); end
    tx(2, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsAckAt !== 4 || obsDat !== 32'h0000_5678) begin failures++; $display("[TB] FAIL after_abort at=%0d got=%h exp 4/00005678", obsAckAt, obsDat); end
    checks++;
    if (accV[2] !== 16'(expAcc[2])) begin failures++; $display("[TB] FAIL after_abort_acc got=%0d exp=%0d", accV[2], expAcc[2]); end
  endtask

  task automatic test_dbg_trig();
    tx(0, 1'b1, 32'h10, 4'hF, 32'hA5A5_A5A5, 0);
    checks++;
    if (obsTrig !== 1'b1 || obsNTrig !== 1) begin failures++; $display("[TB] FAIL trig_wr at_ack=%b n=%0d exp 1/1", obsTrig, obsNTrig); end
    tx(0, 1'b0, 32'h13, 4'hF, 32'h0, 0);
    checks++;
    if (obsTrig !== 1'b1 || obsNTrig !== 1) begin failures++; $display("[TB] FAIL trig_rd13 at_ack=%b n=%0d exp 1/1", obsTrig, obsNTrig); end
    checks++;
    if (obsDat !== 32'hA5A5_A5A5) begin failures++; $display("[TB] FAIL trig_dat got=%h exp=a5a5a5a5", obsDat); end
    tx(0, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsNAck !== 1 || obsNTrig !== 0) begin failures++; $display("[TB] FAIL trig_other ack=%0d trig=%0d exp 1/0", obsNAck, obsNTrig); end
  endtask

  task automatic test_reset_in_rwait();
    int nAck, nErr;
    nAck = 0; nErr = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14; sel = 4'hF;
    @(posedge clk);
    #1;
    stb = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ackV[2]) nAck++;
      if (errV[2]) nErr++;
    end
    cyc = 1'b0;
    for (int i = 0; i < 3; i++) expAcc[i] = 0;
    checks++;
    if (nAck !== 0 || nErr !== 0) begin failures++; $display("[TB] FAIL rst_rwait_resp ack=%0d err=%0d exp 0/0", nAck, nErr); end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (accV[d] !== 16'h0) begin failures++; $display("[TB] FAIL rst_rwait_acc[%0d] got=%0d exp=0", d, accV[d]); end
    end
    tx(2, 1'b0, 32'h14, 4'hF, 32'h0, 0);
    checks++;
    if (obsAckAt !== 4 || obsDat !== 32'h0000_5678 || accV[2] !== 16'd1) begin failures++; $display("[TB] FAIL rst_recover at=%0d dat=%h acc=%0d exp 4/00005678/1", obsAckAt, obsDat, accV[2]); end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_read_wait();
    test_out_of_range();
    test_write_protect();
    test_abort();
    test_dbg_trig();
    test_reset_in_rwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
